// File: rtl/frame_sequencer_pkg.sv
// Shared definitions for the frame sequencer.
// Contents:
//   seq_state_e - frame sequencer state encoding (SEQ_IDLE/SEQ_RUN/SEQ_FLUSH)
//   OVR_W       - width of the saturating overrun counter
//   sat_inc_ovr - saturating increment used for the overrun counter
package frame_sequencer_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_FLUSH = 2'd2
    } seq_state_e;

    localparam int OVR_W = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [OVR_W-1:0] sat_inc_ovr(input logic [OVR_W-1:0] v);
        logic [OVR_W-1:0] r;
        if (v == {OVR_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(OVR_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_sequencer_watchdog.sv
// Frame cycle watchdog: counts RUN cycles of the current frame, flags when the
// frame is about to exceed cycle_limit, and latches the frame length when the
// frame either completes or is aborted.
// Ports:
//   clk, reset      - clock, synchronous active-low reset
//   active          - sequencer is in RUN this cycle
//   frame_end       - frame completes at the end of this cycle
//   expired         - this RUN cycle is cycle number cycle_limit (abort now)
//   frame_cycles    - RUN-cycle length of the last completed/aborted frame
module frame_watchdog #(
    parameter int cycle_limit = 4096,
    parameter int CW          = $clog2(cycle_limit + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          active,
    input  logic          frame_end,
    output logic          expired,
    output logic [CW-1:0] frame_cycles
);

    localparam logic [CW-1:0] LIMIT_C = CW'(cycle_limit);
    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic          expired_s;
    logic [CW-1:0] frame_cycles_r;

    // cnt_next_s is the number of RUN cycles including the current one.
    always_comb begin
        cnt_next_s = cnt_r + ONE_C;
        expired_s  = active && (cnt_next_s >= LIMIT_C);
    end

    // Cycle counter runs only in RUN and is zeroed otherwise, so each frame starts at 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r          <= {CW{1'b0}};
            frame_cycles_r <= {CW{1'b0}};
        end else begin
            if (active) begin
                cnt_r <= cnt_next_s;
            end else begin
                cnt_r <= {CW{1'b0}};
            end
            if (active && (frame_end || expired_s)) begin
                frame_cycles_r <= cnt_next_s;
            end else begin
                frame_cycles_r <= frame_cycles_r;
            end
        end
    end

    assign expired      = expired_s;
    assign frame_cycles = frame_cycles_r;

endmodule

// File: rtl/frame_sequencer.sv
// Per-sample controller for the instruction fetch/decode pipeline. Each sample
// tick opens a frame (pipe_enable high) that ends once every running block has
// retired once. Geometry changes are applied only between frames, followed by a
// one-cycle pipeline flush. Overruns and hung frames are flagged.
// Ports:
//   clk, reset                        - clock, synchronous active-low reset
//   sample_tick                       - one pulse per audio sample
//   cfg_update_req/cfg_n_blocks       - host geometry request (held until ack)
//   cfg_update_ack                    - one-cycle pulse when geometry applied
//   retire_valid                      - one pulse per committed block instruction
//   pipe_enable/pipe_flush            - pipeline enable and flush pulse
//   n_blocks_running/last_block       - current geometry
//   frame_done/busy                   - frame completion pulse, RUN indicator
//   overrun/overrun_count             - sticky overrun flag, saturating count
//   timeout/frame_cycles              - sticky watchdog flag, last frame length
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter  int n_blocks    = 256,
    parameter  int cycle_limit = 4096,
    localparam int BW          = $clog2(n_blocks),
    localparam int CW          = $clog2(cycle_limit + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_tick,
    input  logic             cfg_update_req,
    input  logic [BW-1:0]    cfg_n_blocks,
    output logic             cfg_update_ack,
    input  logic             retire_valid,
    output logic             pipe_enable,
    output logic             pipe_flush,
    output logic [BW-1:0]    n_blocks_running,
    output logic [BW-1:0]    last_block,
    output logic             frame_done,
    output logic             busy,
    output logic             overrun,
    output logic [OVR_W-1:0] overrun_count,
    output logic             timeout,
    output logic [CW-1:0]    frame_cycles
);

    seq_state_e       state_r;
    logic             tick_pending_r;
    logic [BW:0]      retire_cnt_r;
    logic [BW-1:0]    n_blocks_r;
    logic [BW-1:0]    last_block_r;
    logic             ack_r;
    logic             pipe_enable_r;
    logic             pipe_flush_r;
    logic             frame_done_r;
    logic             busy_r;
    logic             overrun_r;
    logic [OVR_W-1:0] overrun_count_r;
    logic             timeout_r;

    logic             run_s;
    logic [BW:0]      retire_sum_s;
    logic             done_now_s;
    logic             expired_s;
    logic             abort_s;
    logic [BW-1:0]    cfg_last_s;

    // Frame completion, watchdog abort and the last-block index of a requested geometry.
    always_comb begin
        run_s        = (state_r == SEQ_RUN);
        retire_sum_s = retire_cnt_r + {{BW{1'b0}}, retire_valid};
        done_now_s   = run_s && (retire_sum_s == {1'b0, n_blocks_r});
        // Completion wins over a watchdog expiry in the same cycle.
        abort_s      = run_s && expired_s && !done_now_s;
        if (cfg_n_blocks == {BW{1'b0}}) begin
            cfg_last_s = {BW{1'b0}};
        end else begin
            cfg_last_s = cfg_n_blocks - {{(BW-1){1'b0}}, 1'b1};
        end
    end

    frame_watchdog #(
        .cycle_limit (cycle_limit),
        .CW          (CW)
    ) u_watchdog (
        .clk          (clk),
        .reset        (reset),
        .active       (run_s),
        .frame_end    (done_now_s),
        .expired      (expired_s),
        .frame_cycles (frame_cycles)
    );

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r         <= SEQ_IDLE;
            tick_pending_r  <= 1'b0;
            retire_cnt_r    <= {(BW+1){1'b0}};
            n_blocks_r      <= {BW{1'b0}};
            last_block_r    <= {BW{1'b0}};
            ack_r           <= 1'b0;
            pipe_enable_r   <= 1'b0;
            pipe_flush_r    <= 1'b0;
            frame_done_r    <= 1'b0;
            busy_r          <= 1'b0;
            overrun_r       <= 1'b0;
            overrun_count_r <= {OVR_W{1'b0}};
            timeout_r       <= 1'b0;
        end else begin
            ack_r        <= 1'b0;
            pipe_flush_r <= 1'b0;
            frame_done_r <= 1'b0;

            // A tick outside IDLE is an overrun; only the first one is queued.
            if (sample_tick && (state_r != SEQ_IDLE)) begin
                overrun_r       <= 1'b1;
                overrun_count_r <= sat_inc_ovr(overrun_count_r);
                tick_pending_r  <= 1'b1;
            end else begin
                overrun_count_r <= overrun_count_r;
            end

            case (state_r)
                SEQ_IDLE: begin
                    if (cfg_update_req) begin
                        n_blocks_r    <= cfg_n_blocks;
                        last_block_r  <= cfg_last_s;
                        ack_r         <= 1'b1;
                        pipe_flush_r  <= 1'b1;
                        pipe_enable_r <= 1'b0;
                        busy_r        <= 1'b0;
                        state_r       <= SEQ_FLUSH;
                        if (sample_tick) begin
                            tick_pending_r <= 1'b1;
                        end else begin
                            tick_pending_r <= tick_pending_r;
                        end
                    end else if (sample_tick || tick_pending_r) begin
                        tick_pending_r <= 1'b0;
                        retire_cnt_r   <= {(BW+1){1'b0}};
                        if (n_blocks_r == {BW{1'b0}}) begin
                            // Empty program: the frame is trivially complete.
                            frame_done_r <= 1'b1;
                            state_r      <= SEQ_IDLE;
                        end else begin
                            pipe_enable_r <= 1'b1;
                            busy_r        <= 1'b1;
                            state_r       <= SEQ_RUN;
                        end
                    end else begin
                        state_r <= SEQ_IDLE;
                    end
                end
                SEQ_RUN: begin
                    retire_cnt_r <= retire_sum_s;
                    if (done_now_s) begin
                        // Pipeline is stalled, not flushed: prefetched work resumes next frame.
                        pipe_enable_r <= 1'b0;
                        busy_r        <= 1'b0;
                        frame_done_r  <= 1'b1;
                        state_r       <= SEQ_IDLE;
                    end else if (abort_s) begin
                        timeout_r     <= 1'b1;
                        pipe_enable_r <= 1'b0;
                        busy_r        <= 1'b0;
                        pipe_flush_r  <= 1'b1;
                        state_r       <= SEQ_FLUSH;
                    end else begin
                        state_r <= SEQ_RUN;
                    end
                end
                SEQ_FLUSH: begin
                    pipe_enable_r <= 1'b0;
                    busy_r        <= 1'b0;
                    state_r       <= SEQ_IDLE;
                end
                default: begin
                    pipe_enable_r <= 1'b0;
                    busy_r        <= 1'b0;
                    state_r       <= SEQ_IDLE;
                end
            endcase
        end
    end

    assign cfg_update_ack   = ack_r;
    assign pipe_enable      = pipe_enable_r;
    assign pipe_flush       = pipe_flush_r;
    assign n_blocks_running = n_blocks_r;
    assign last_block       = last_block_r;
    assign frame_done       = frame_done_r;
    assign busy             = busy_r;
    assign overrun          = overrun_r;
    assign overrun_count    = overrun_count_r;
    assign timeout          = timeout_r;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed self-checking bench for frame_sequencer (cycle_limit overridden to 16).
module tb_frame_sequencer;

    localparam int BW = 8;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          sample_tick;
    logic          cfg_update_req;
    logic [BW-1:0] cfg_n_blocks;
    logic          cfg_update_ack;
    logic          retire_valid;
    logic          pipe_enable;
    logic          pipe_flush;
    logic [BW-1:0] n_blocks_running;
    logic [BW-1:0] last_block;
    logic          frame_done;
    logic          busy;
    logic          overrun;
    logic [7:0]    overrun_count;
    logic          timeout;
    logic [CW-1:0] frame_cycles;

    int checks_n = 0;
    int errors_n = 0;
    logic fd_seen;

    frame_sequencer #(.n_blocks(256), .cycle_limit(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .sample_tick      (sample_tick),
        .cfg_update_req   (cfg_update_req),
        .cfg_n_blocks     (cfg_n_blocks),
        .cfg_update_ack   (cfg_update_ack),
        .retire_valid     (retire_valid),
        .pipe_enable      (pipe_enable),
        .pipe_flush       (pipe_flush),
        .n_blocks_running (n_blocks_running),
        .last_block       (last_block),
        .frame_done       (frame_done),
        .busy             (busy),
        .overrun          (overrun),
        .overrun_count    (overrun_count),
        .timeout          (timeout),
        .frame_cycles     (frame_cycles)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_n++;
        if (got !== exp) begin
            errors_n++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge, then settle so outputs reflect that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [BW-1:0] n);
        cfg_n_blocks   = n;
        cfg_update_req = 1'b1;
        step();
        cfg_update_req = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b0; sample_tick = 1'b0; cfg_update_req = 1'b0;
        cfg_n_blocks = '0; retire_valid = 1'b0;
        step(); step();
        check_eq("rst_pe", 32'(pipe_enable), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_nbr", 32'(n_blocks_running), 32'd0);
        check_eq("rst_fc", 32'(frame_cycles), 32'd0);
        check_eq("rst_ovc", 32'(overrun_count), 32'd0);
        reset = 1'b1;
        step();

        // Config then run with 4 blocks
        cfg_n_blocks = 8'd4; cfg_update_req = 1'b1;
        step();
        check_eq("cfg_ack", 32'(cfg_update_ack), 32'd1);
        check_eq("cfg_nbr", 32'(n_blocks_running), 32'd4);
        check_eq("cfg_last", 32'(last_block), 32'd3);
        check_eq("cfg_flush", 32'(pipe_flush), 32'd1);
        cfg_update_req = 1'b0;
        step();
        check_eq("cfg_ack_off", 32'(cfg_update_ack), 32'd0);
        check_eq("cfg_flush_off", 32'(pipe_flush), 32'd0);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check_eq("run_pe", 32'(pipe_enable), 32'd1);
        check_eq("run_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            retire_valid = 1'b1;
            step();
            if (i < 3) begin
                check_eq("run_pe_hold", 32'(pipe_enable), 32'd1);
                check_eq("run_fd_early", 32'(frame_done), 32'd0);
            end
        end
        retire_valid = 1'b0;
        check_eq("run_fd", 32'(frame_done), 32'd1);
        check_eq("run_pe_off", 32'(pipe_enable), 32'd0);
        check_eq("run_fc", 32'(frame_cycles), 32'd4);
        check_eq("run_ovr", 32'(overrun), 32'd0);
        step();
        check_eq("run_fd_pulse", 32'(frame_done), 32'd0);

        // Zero blocks
        configure(8'd0);
        check_eq("zero_nbr", 32'(n_blocks_running), 32'd0);
        check_eq("zero_last", 32'(last_block), 32'd0);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check_eq("zero_fd", 32'(frame_done), 32'd1);
        check_eq("zero_pe", 32'(pipe_enable), 32'd0);
        step();
        check_eq("zero_fd_off", 32'(frame_done), 32'd0);
        check_eq("zero_pe2", 32'(pipe_enable), 32'd0);

        // Overrun: 3 ticks inside one 4-block frame
        configure(8'd4);
        sample_tick = 1'b1;
        step();
        check_eq("ovr_pe", 32'(pipe_enable), 32'd1);
        sample_tick = 1'b1; retire_valid = 1'b1; step();
        sample_tick = 1'b0; retire_valid = 1'b1; step();
        sample_tick = 1'b1; retire_valid = 1'b0; step();
        sample_tick = 1'b1; retire_valid = 1'b1; step();
        sample_tick = 1'b0; retire_valid = 1'b1; step();
        retire_valid = 1'b0;
        check_eq("ovr_fd", 32'(frame_done), 32'd1);
        check_eq("ovr_flag", 32'(overrun), 32'd1);
        check_eq("ovr_cnt", 32'(overrun_count), 32'd3);
        step();
        check_eq("ovr_restart", 32'(pipe_enable), 32'd1);
        for (int i = 0; i < 4; i++) begin
            retire_valid = 1'b1;
            step();
        end
        retire_valid = 1'b0;
        check_eq("ovr_fd2", 32'(frame_done), 32'd1);
        step();
        check_eq("ovr_no_extra1", 32'(pipe_enable), 32'd0);
        step();
        check_eq("ovr_no_extra2", 32'(pipe_enable), 32'd0);
        check_eq("ovr_cnt_hold", 32'(overrun_count), 32'd3);

        // Reconfig/tick collision
        cfg_n_blocks = 8'd2; cfg_update_req = 1'b1; sample_tick = 1'b1;
        step();
        cfg_update_req = 1'b0; sample_tick = 1'b0;
        check_eq("col_ack", 32'(cfg_update_ack), 32'd1);
        check_eq("col_flush", 32'(pipe_flush), 32'd1);
        check_eq("col_nbr", 32'(n_blocks_running), 32'd2);
        step();
        check_eq("col_idle_pe", 32'(pipe_enable), 32'd0);
        check_eq("col_idle_flush", 32'(pipe_flush), 32'd0);
        step();
        check_eq("col_run_pe", 32'(pipe_enable), 32'd1);
        retire_valid = 1'b1; step();
        check_eq("col_fd_early", 32'(frame_done), 32'd0);
        step();
        retire_valid = 1'b0;
        check_eq("col_fd", 32'(frame_done), 32'd1);
        check_eq("col_ovc", 32'(overrun_count), 32'd3);
        step();

        // Watchdog: 4 blocks, only 2 retires
        configure(8'd4);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        fd_seen = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            retire_valid = (i <= 2);
            step();
            fd_seen = fd_seen | frame_done;
            if (i == 15) begin
                check_eq("wd_pre_to", 32'(timeout), 32'd0);
                check_eq("wd_pre_pe", 32'(pipe_enable), 32'd1);
            end
        end
        retire_valid = 1'b0;
        check_eq("wd_timeout", 32'(timeout), 32'd1);
        check_eq("wd_fc", 32'(frame_cycles), 32'd16);
        check_eq("wd_flush", 32'(pipe_flush), 32'd1);
        check_eq("wd_pe", 32'(pipe_enable), 32'd0);
        step();
        fd_seen = fd_seen | frame_done;
        check_eq("wd_no_fd", 32'(fd_seen), 32'd0);
        check_eq("wd_flush_off", 32'(pipe_flush), 32'd0);

        // Reset mid-frame
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check_eq("mr_pe", 32'(pipe_enable), 32'd1);
        retire_valid = 1'b1; step();
        retire_valid = 1'b0;
        reset = 1'b0;
        step();
        check_eq("mr_pe_off", 32'(pipe_enable), 32'd0);
        check_eq("mr_busy", 32'(busy), 32'd0);
        check_eq("mr_nbr", 32'(n_blocks_running), 32'd0);
        check_eq("mr_ovr", 32'(overrun), 32'd0);
        check_eq("mr_to", 32'(timeout), 32'd0);
        check_eq("mr_fc", 32'(frame_cycles), 32'd0);
        reset = 1'b1;
        step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check_eq("mr_tick_pe", 32'(pipe_enable), 32'd0);
        step();
        check_eq("mr_tick_pe2", 32'(pipe_enable), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors_n, checks_n);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Per-sample controller for the instruction fetch/decode pipeline.
- On each sample tick it opens one frame: it raises the pipeline enable and counts retired block instructions until every running block has committed once, then closes the frame.
- It owns the running program geometry (n_blocks_running, last_block). It applies host reconfiguration only between frames, with a one-cycle pipeline flush.
- It detects overruns (tick arrives mid-frame) and hung frames (cycle watchdog).

Parameters:
- n_blocks, 256, block slots in instruction memory; block-count/index width BW = $clog2(n_blocks).
- cycle_limit, 4096, max cycles a frame may stay in RUN before watchdog abort.
- CW, $clog2(cycle_limit+1), width of cycle counters.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low (0 = reset, sampled on posedge clk).
- sample_tick  input  1  one-cycle pulse per audio sample.
- cfg_update_req  input  1  host requests new geometry; held until ack.
- cfg_n_blocks  input  BW  requested block count; stable while req high.
- cfg_update_ack  output  1  one-cycle pulse when cfg applied.
- retire_valid  input  1  one-cycle pulse per block instruction committed (pipeline commit flag).
- pipe_enable  output  1  drives fetch/decode and downstream enable.
- pipe_flush  output  1  one-cycle pulse; ORed into pipeline reset.
- n_blocks_running  output  BW  current block count.
- last_block  output  BW  n_blocks_running-1, or 0 when count is 0.
- frame_done  output  1  one-cycle pulse at frame completion.
- busy  output  1  high in RUN.
- overrun  output  1  sticky; cleared only by reset.
- overrun_count  output  8  saturating count of overrun ticks.
- timeout  output  1  sticky watchdog flag.
- frame_cycles  output  CW  RUN-cycle length of the last completed or aborted frame.

Behaviour:
- Reset values: all outputs 0, state IDLE, tick_pending 0, retire counter 0, cycle counter 0.
- States:
  - IDLE: pipe_enable=0.
  - RUN: pipe_enable=1, busy=1.
  - FLUSH: pipe_enable=0, pipe_flush=1 for exactly one cycle.
- IDLE priority, evaluated each cycle: cfg_update_req > (sample_tick | tick_pending) > stay.
- IDLE + cfg_update_req:
  - Load n_blocks_running and last_block from cfg_n_blocks; pulse cfg_update_ack.
  - Go to FLUSH. A sample_tick in the same cycle sets tick_pending.
- FLUSH always returns to IDLE next cycle.
- IDLE + tick:
  - If n_blocks_running==0: stay IDLE, pulse frame_done next cycle, clear tick_pending.
  - Otherwise go to RUN. Counters cleared, tick_pending cleared.
  - Latency: tick at cycle T gives pipe_enable=1 at T+1.
- RUN, each cycle:
  - Cycle counter increments.
  - retire_valid increments the retire counter.
  - When the retire counter plus the current retire equals n_blocks_running: go to IDLE. pipe_enable=0 and frame_done=1 at the next cycle, and frame_cycles is latched.
  - Prefetched instructions stay held in the stalled pipeline and resume next frame; no flush.
- sample_tick in RUN or FLUSH:
  - Set overrun.
  - If tick_pending is already 1, only increment overrun_count (saturate at 255).
  - Otherwise set tick_pending and also increment overrun_count. A pending tick starts the next frame from IDLE one cycle after completion.
- Watchdog: if the cycle counter reaches cycle_limit in RUN, set timeout, latch frame_cycles, and go to FLUSH. No frame_done for the aborted frame.
- Not accepted outside IDLE:
  - cfg_update_req is ignored while in RUN or FLUSH; the host keeps holding it.
  - retire_valid outside RUN is ignored.
- Retire counter width is BW+1, so no wrap for n_blocks_running up to 2^BW-1.
- Reset mid-frame: return to IDLE immediately next edge with all outputs at reset values; geometry is cleared to 0.

Decomposition:
- Shared package core.vh: state encoding constants SEQ_IDLE/SEQ_RUN/SEQ_FLUSH, and the overrun_count width.
- One natural sub-module: frame_watchdog (cycle counter, limit compare, frame_cycles latch). The FSM stays in frame_sequencer.

Test Plan:
- Config then run: set cfg_n_blocks=4 and req. Expect ack 1 cycle later, n_blocks_running=4, last_block=3, pipe_flush one pulse. Then send a tick, then 4 retire pulses. Expect pipe_enable high for the whole frame, frame_done one cycle after the 4th retire, overrun=0.
- Zero blocks: with n_blocks_running=0, send a tick. Expect pipe_enable never high and frame_done one cycle after the tick.
- Overrun: with 4 blocks, send 3 ticks during one frame. Expect overrun=1 and overrun_count=3. The next frame starts one cycle after frame_done, with only one extra frame run.
- Reconfig vs tick collision: in IDLE, drive req (cfg_n_blocks=2) and a tick in the same cycle. Expect ack, then flush, then IDLE, then RUN. The frame completes after 2 retires.
- Watchdog: with cycle_limit=16, 4 blocks, and only 2 retires sent, send a tick. Expect timeout=1 after 16 RUN cycles, frame_cycles=16, a flush pulse, and no frame_done.
- Reset mid-frame: assert reset (0) during RUN. Expect pipe_enable=0 and all outputs 0 on the next edge; a later tick does not start a frame until reconfigured.
